// File: rtl/spi_adc_responder.sv
// SPI responder emulating a serial 8-bit ADC: frames one held sample MSB-first
// with leading/trailing zeros; cs_n/sclk synchronised, edges detected on clk.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   cs_n, sclk               async master frame select / serial clock
//   sdata, sdata_oe          serial data out and its pad enable
//   sample_data/valid/ready  holding-register handshake for the next sample
//   busy                     frame in progress
//   frame_done/abort, stale  single-clk status pulses
module spi_adc_responder #(
  parameter int DATA_BITS   = 8,
  parameter int LEAD_ZEROS  = 3,
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cs_n,
  input  logic                 sclk,
  output logic                 sdata,
  output logic                 sdata_oe,
  input  logic [DATA_BITS-1:0] sample_data,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_abort,
  output logic                 stale
);

  localparam int CW = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sc_sync_q;
  logic                   cs_prev_q;
  logic                   sc_prev_q;

  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_BITS-1:0]  hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0]  last_q, last_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;
  logic                  stale_q, stale_d;

  logic                  cs_s, sc_s;
  logic                  cs_fall, cs_rise;
  logic                  sc_fall, sc_rise;
  logic                  accept;
  logic [DATA_BITS-1:0]  pick;
  logic [FRAME_BITS-1:0] load_w;
  logic [CW-1:0]         cnt_inc;

  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign sc_s    = sc_sync_q[SYNC_STAGES-1];
  assign cs_fall = cs_prev_q & ~cs_s;
  assign cs_rise = ~cs_prev_q & cs_s;
  assign sc_fall = sc_prev_q & ~sc_s;
  assign sc_rise = ~sc_prev_q & sc_s;
  assign accept  = sample_valid & ~hold_full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_q   <= '1;
      sc_sync_q   <= '1;
      cs_prev_q   <= 1'b1;
      sc_prev_q   <= 1'b1;
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      last_q      <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      stale_q     <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      sc_sync_q   <= {sc_sync_q[SYNC_STAGES-2:0], sclk};
      cs_prev_q   <= cs_s;
      sc_prev_q   <= sc_s;
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      last_q      <= last_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      stale_q     <= stale_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    last_d      = last_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    stale_d     = 1'b0;
    cnt_inc     = cnt_q + 1'b1;

    // A fresh sample wins; otherwise the previous one is resent.
    pick   = hold_full_q ? hold_q : last_q;
    load_w = '0;
    load_w[FRAME_BITS-1-LEAD_ZEROS -: DATA_BITS] = pick;

    // cs_n edges are checked first so a coincident sclk edge is dropped.
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d     = ACTIVE;
          shift_d     = load_w;
          cnt_d       = '0;
          stale_d     = ~hold_full_q;
          last_d      = pick;
          hold_full_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (sc_fall) begin
          shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
        end else if (sc_rise) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(FRAME_BITS)) begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (cs_rise) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Only possible when empty, so a same-clk load leaves this sample queued.
    if (accept) begin
      hold_d      = sample_data;
      hold_full_d = 1'b1;
    end
  end

  assign sdata        = (state_q == ACTIVE) & shift_q[FRAME_BITS-1];
  assign sdata_oe     = (state_q != IDLE);
  assign busy         = (state_q != IDLE);
  assign sample_ready = ~hold_full_q;
  assign frame_done   = done_q;
  assign frame_abort  = abort_q;
  assign stale        = stale_q;

endmodule
